axi4l_copy_dma: RTL and testbench



---
 rtl/axi4l_pkg.sv | 16 +
 rtl/axi4l_if.sv | 43 ++++
 rtl/axi4l_copy_dma.sv | 197 +++++++++++++++++++
 tb/tb_axi4l_copy_dma.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions used by initiators and slaves on the interconnect.
//   axi4l_resp_e : encoding of RRESP/BRESP.
//   AXI4L_AW/DW  : address and data widths of the bus.
package axi4l_pkg;

  localparam int unsigned AXI4L_AW = 32;
  localparam int unsigned AXI4L_DW = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_e;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle connecting one initiator to one target port.
//   aclk, aresetn : bus clock and active-low reset (inputs to the bundle)
//   AW/W/B        : write address, write data, write response channels
//   AR/R          : read address, read data channels
// Modports: master (initiator side), slave (target side).
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    input  aclk, aresetn,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  aclk, aresetn,
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_copy_dma.sv
// Single-channel AXI4-Lite copy engine: reads one word from the source range,
// writes it to the destination range, and repeats, one word in flight.
//   clk, rst          : clock (same net as axi.aclk), synchronous active-high reset
//   start             : one-cycle request, honoured only when idle
//   src_addr/dst_addr : byte addresses, word aligned on capture
//   len_words         : number of 32-bit words to copy (0 = no bus activity)
//   busy              : transfer in progress
//   done              : one-cycle pulse at the end of every transfer
//   error, err_addr   : sticky failure flag and address of the failing beat
//   axi               : AXI4-Lite initiator port
module axi4l_copy_dma
  import axi4l_pkg::*;
#(
  parameter int unsigned LenWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LenWidth-1:0] len_words,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [31:0]         err_addr,
  axi4l_if.master             axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e              state;
  logic [31:0]         src_q;
  logic [31:0]         dst_q;
  logic [LenWidth-1:0] remaining;
  logic [31:0]         word_buf;
  logic [31:0]         araddr_q;
  logic [31:0]         awaddr_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                aw_done;
  logic                w_done;

  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  // A write beat is complete once each channel has handshaked, now or earlier.
  always_comb begin
    aw_hs = awvalid_q && axi.awready;
    w_hs  = wvalid_q && axi.wready;
    aw_ok = aw_done || aw_hs;
    w_ok  = w_done || w_hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      remaining <= '0;
      word_buf  <= '0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (len_words != '0) begin
              src_q     <= src_addr & ~32'd3;
              dst_q     <= dst_addr & ~32'd3;
              remaining <= len_words;
              araddr_q  <= src_addr & ~32'd3;
              arvalid_q <= 1'b1;
              busy      <= 1'b1;
              state     <= RD_ADDR;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end

        RD_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            word_buf <= axi.rdata;
            if (axi4l_resp_e'(axi.rresp) != OKAY) begin
              error    <= 1'b1;
              err_addr <= src_q;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
            end else begin
              awaddr_q  <= dst_q;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR;
            end
          end
        end

        WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // Completion overrides the per-channel flags set just above.
          if (aw_ok && w_ok) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            if (axi4l_resp_e'(axi.bresp) != OKAY) begin
              error    <= 1'b1;
              err_addr <= dst_q;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
            end else begin
              src_q     <= src_q + 32'd4;
              dst_q     <= dst_q + 32'd4;
              remaining <= remaining - LenWidth'(1);
              if (remaining == LenWidth'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                araddr_q  <= src_q + 32'd4;
                arvalid_q <= 1'b1;
                state     <= RD_ADDR;
              end
            end
          end
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = word_buf;
  assign axi.wstrb   = wvalid_q ? 4'hF : 4'h0;
  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi4l_copy_dma.sv
// Directed bench for axi4l_copy_dma with a behavioural AXI4-Lite slave.
// Slave map: 0x2xxxxxxx decode error, 0x3xxxxxxx write slave error, else OKAY.
module tb_axi4l_copy_dma;
  import axi4l_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_addr;

  axi4l_if axi_bus (.aclk(clk), .aresetn(~rst));

  axi4l_copy_dma #(.LenWidth(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_addr  (err_addr),
    .axi       (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- slave model ----------------
  logic [31:0] rom  [logic [31:0]];
  logic [31:0] wmem [logic [31:0]];
  int          bp_mode = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] last_awaddr = '0;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  int          aw_age;
  logic        aw_now, w_now;
  logic [31:0] wa, wd;

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    return rom.exists(a) ? rom[a] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] wm(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : 32'hBAD0BAD0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      axi_bus.arready <= 1'b0;
      axi_bus.awready <= 1'b0;
      axi_bus.wready  <= 1'b0;
      axi_bus.rvalid  <= 1'b0;
      axi_bus.rdata   <= '0;
      axi_bus.rresp   <= '0;
      axi_bus.bvalid  <= 1'b0;
      axi_bus.bresp   <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      aw_age <= 0;
    end else begin
      case (bp_mode)
        1: begin
          axi_bus.arready <= 1'($urandom_range(0, 1));
          axi_bus.awready <= 1'($urandom_range(0, 1));
          axi_bus.wready  <= 1'($urandom_range(0, 1));
        end
        2: begin
          axi_bus.arready <= 1'b1;
          axi_bus.awready <= 1'b1;
          axi_bus.wready  <= (aw_age >= 4);
        end
        default: begin
          axi_bus.arready <= 1'b1;
          axi_bus.awready <= 1'b1;
          axi_bus.wready  <= 1'b1;
        end
      endcase
      aw_age <= (aw_got && !w_got) ? aw_age + 1 : 0;

      if (axi_bus.arvalid && axi_bus.arready) begin
        axi_bus.rvalid <= 1'b1;
        axi_bus.rdata  <= rom_rd(axi_bus.araddr);
        axi_bus.rresp  <= (axi_bus.araddr[31:28] == 4'h2) ? 2'(DECERR) : 2'(OKAY);
        ar_cnt <= ar_cnt + 1;
      end else if (axi_bus.rvalid && axi_bus.rready) begin
        axi_bus.rvalid <= 1'b0;
      end

      if (axi_bus.awvalid && axi_bus.awready) begin
        aw_got      <= 1'b1;
        aw_addr_q   <= axi_bus.awaddr;
        last_awaddr <= axi_bus.awaddr;
        aw_cnt      <= aw_cnt + 1;
      end
      if (axi_bus.wvalid && axi_bus.wready) begin
        w_got    <= 1'b1;
        w_data_q <= axi_bus.wdata;
        w_cnt    <= w_cnt + 1;
      end
      aw_now = aw_got || (axi_bus.awvalid && axi_bus.awready);
      w_now  = w_got || (axi_bus.wvalid && axi_bus.wready);
      wa = aw_got ? aw_addr_q : axi_bus.awaddr;
      wd = w_got ? w_data_q : axi_bus.wdata;
      if (aw_now && w_now && !axi_bus.bvalid) begin
        axi_bus.bvalid <= 1'b1;
        if (wa[31:28] == 4'h3)      axi_bus.bresp <= 2'(SLVERR);
        else if (wa[31:28] == 4'h2) axi_bus.bresp <= 2'(DECERR);
        else begin
          axi_bus.bresp <= 2'(OKAY);
          wmem[wa] = wd;
        end
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (axi_bus.bvalid && axi_bus.bready) begin
        axi_bus.bvalid <= 1'b0;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int          done_cnt = 0;
  int          stab_errs = 0;
  logic        ar_pend = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
  logic [31:0] ar_hold, aw_hold, w_hold;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rst) begin
      ar_pend = 1'b0;
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end else begin
      if (ar_pend && (axi_bus.arvalid !== 1'b1 || axi_bus.araddr !== ar_hold)) stab_errs++;
      if (aw_pend && (axi_bus.awvalid !== 1'b1 || axi_bus.awaddr !== aw_hold)) stab_errs++;
      if (w_pend && (axi_bus.wvalid !== 1'b1 || axi_bus.wdata !== w_hold)) stab_errs++;
      ar_pend = axi_bus.arvalid && !axi_bus.arready;
      aw_pend = axi_bus.awvalid && !axi_bus.awready;
      w_pend  = axi_bus.wvalid && !axi_bus.wready;
      ar_hold = axi_bus.araddr;
      aw_hold = axi_bus.awaddr;
      w_hold  = axi_bus.wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len_words = n;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle count is relative to the edge that accepted start (returns at done).
  task automatic wait_done(input int from, input int limit, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) check("done_timeout", {31'b0, done}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},    {31'b0, busy}, 32'h0);
    check({pfx, "_done"},    {31'b0, done}, 32'h0);
    check({pfx, "_error"},   {31'b0, error}, 32'h0);
    check({pfx, "_err_addr"}, err_addr, 32'h0);
    check({pfx, "_arvalid"}, {31'b0, axi_bus.arvalid}, 32'h0);
    check({pfx, "_rready"},  {31'b0, axi_bus.rready}, 32'h0);
    check({pfx, "_awvalid"}, {31'b0, axi_bus.awvalid}, 32'h0);
    check({pfx, "_wvalid"},  {31'b0, axi_bus.wvalid}, 32'h0);
    check({pfx, "_bready"},  {31'b0, axi_bus.bready}, 32'h0);
    check({pfx, "_araddr"},  axi_bus.araddr, 32'h0);
    check({pfx, "_awaddr"},  axi_bus.awaddr, 32'h0);
    check({pfx, "_wdata"},   axi_bus.wdata, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int d0, a0, aw0, w0;

    rst = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len_words = '0;
    for (int unsigned i = 0; i < 4; i++) rom[32'h100 + 4 * i] = 32'hA0 + i;
    for (int unsigned i = 0; i < 8; i++) rom[32'h400 + 4 * i] = 32'h1000 + i;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic copy, zero-wait slave: done 4*4+1 cycles after start
    d0 = done_cnt;
    start_xfer(32'h100, 32'h200, 16'd4);
    check("copy_busy_n1",    {31'b0, busy}, 32'h1);
    check("copy_arvalid_n1", {31'b0, axi_bus.arvalid}, 32'h1);
    check("copy_araddr_n1",  axi_bus.araddr, 32'h100);
    wait_done(1, 200, cyc);
    check("copy_latency", cyc, 32'd17);
    check("copy_busy_at_done", {31'b0, busy}, 32'h0);
    check("copy_error", {31'b0, error}, 32'h0);
    repeat (2) @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) check("copy_word", wm(32'h200 + 4 * i), 32'hA0 + i);
    check("copy_done_pulses", done_cnt - d0, 32'd1);

    // Peripheral write, single word
    rom[32'h100] = 32'h5;
    d0 = done_cnt;
    start_xfer(32'h100, 32'h10002000, 16'd1);
    wait_done(1, 100, cyc);
    check("periph_latency", cyc, 32'd5);
    repeat (2) @(negedge clk);
    check("periph_led", wm(32'h10002000), 32'h5);
    check("periph_done_pulses", done_cnt - d0, 32'd1);

    // Decode error on first read: no write activity
    d0 = done_cnt; aw0 = aw_cnt; w0 = w_cnt;
    start_xfer(32'h20000000, 32'h200, 16'd3);
    wait_done(1, 100, cyc);
    check("decerr_latency", cyc, 32'd3);
    check("decerr_error", {31'b0, error}, 32'h1);
    check("decerr_err_addr", err_addr, 32'h20000000);
    repeat (2) @(negedge clk);
    check("decerr_error_sticky", {31'b0, error}, 32'h1);
    check("decerr_no_aw", aw_cnt - aw0, 32'd0);
    check("decerr_no_w", w_cnt - w0, 32'd0);
    check("decerr_done_pulses", done_cnt - d0, 32'd1);

    // Zero length: done at N+1, no bus activity, clears error
    a0 = ar_cnt; aw0 = aw_cnt;
    start_xfer(32'h100, 32'h800, 16'd0);
    check("len0_done_n1", {31'b0, done}, 32'h1);
    check("len0_error_cleared", {31'b0, error}, 32'h0);
    check("len0_busy", {31'b0, busy}, 32'h0);
    check("len0_arvalid", {31'b0, axi_bus.arvalid}, 32'h0);
    repeat (2) @(negedge clk);
    check("len0_no_ar", ar_cnt - a0, 32'd0);
    check("len0_no_aw", aw_cnt - aw0, 32'd0);

    // Write response error on first beat
    a0 = ar_cnt;
    start_xfer(32'h104, 32'h30000000, 16'd2);
    wait_done(1, 100, cyc);
    check("slverr_latency", cyc, 32'd5);
    check("slverr_error", {31'b0, error}, 32'h1);
    check("slverr_err_addr", err_addr, 32'h30000000);
    repeat (2) @(negedge clk);
    check("slverr_one_read", ar_cnt - a0, 32'd1);

    // Destination wraps from 0xFFFFFFFC to 0
    start_xfer(32'h100, 32'hFFFFFFFC, 16'd2);
    wait_done(1, 100, cyc);
    check("wrap_latency", cyc, 32'd9);
    check("wrap_error", {31'b0, error}, 32'h0);
    repeat (2) @(negedge clk);
    check("wrap_word0", wm(32'hFFFFFFFC), 32'h5);
    check("wrap_word1", wm(32'h0), 32'hA1);
    check("wrap_awaddr", last_awaddr, 32'h0);

    // Start while busy is ignored
    a0 = ar_cnt;
    start_xfer(32'h100, 32'h300, 16'd2);
    @(negedge clk);
    src_addr = 32'h108; dst_addr = 32'h400; len_words = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, 200, cyc);
    check("ignore_latency", cyc, 32'd9);
    repeat (2) @(negedge clk);
    check("ignore_word0", wm(32'h300), 32'h5);
    check("ignore_word1", wm(32'h304), 32'hA1);
    check("ignore_no_second_dst", {31'b0, wmem.exists(32'h400) ? 1'b1 : 1'b0}, 32'h0);
    check("ignore_reads", ar_cnt - a0, 32'd2);

    // Random ready backpressure, len=8
    bp_mode = 1;
    aw0 = aw_cnt; w0 = w_cnt;
    start_xfer(32'h400, 32'h500, 16'd8);
    wait_done(1, 3000, cyc);
    check("bp_error", {31'b0, error}, 32'h0);
    repeat (2) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) check("bp_word", wm(32'h500 + 4 * i), 32'h1000 + i);
    check("bp_aw_count", aw_cnt - aw0, 32'd8);
    check("bp_w_count", w_cnt - w0, 32'd8);

    // AW accepted several cycles before W
    bp_mode = 2;
    w0 = w_cnt;
    start_xfer(32'h408, 32'h600, 16'd2);
    wait_done(1, 500, cyc);
    repeat (2) @(negedge clk);
    check("awfirst_word0", wm(32'h600), 32'h1002);
    check("awfirst_word1", wm(32'h604), 32'h1003);
    check("awfirst_w_count", w_cnt - w0, 32'd2);
    bp_mode = 0;
    repeat (2) @(negedge clk);

    // Reset during cycle 2 of a transfer, then a fresh transfer
    d0 = done_cnt;
    start_xfer(32'h100, 32'h700, 16'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    start_xfer(32'h400, 32'h700, 16'd4);
    wait_done(1, 200, cyc);
    check("midrst_fresh_latency", cyc, 32'd17);
    repeat (2) @(negedge clk);
    check("midrst_fresh_word0", wm(32'h700), 32'h1000);
    check("midrst_fresh_word3", wm(32'h70C), 32'h1003);

    check("valid_stability", stab_errs, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
